seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor of the integer ALU for the NanoCore execute stage. It keeps the same 5-bit opcode map and adds an XLEN parameter, valid/ready flow control and registered outputs. Multiply and divide run on an internal iterative datapath, so no external multiplier or divider instance is needed. The block sits between operand fetch/issue and writeback, and holds each result until writeback accepts it.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8; shift amount = b[$clog2(XLEN)-1:0]
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation (combinational: state==IDLE && !rst)
- a, b  in  XLEN  operands; captured on accept
- opcode  in  5  operation code; captured on accept
- out_valid  out  1  result/flag valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- alu_flag  out  1  compare outcome (compare ops); 0 for all other ops
- illegal  out  1  opcode ≥ 5'b10110 was issued; result 0, flag 0

## Operation
- Opcodes:
  - 00 ADD, 01 SUB
  - 02 MUL (low XLEN), 03 MULH (s×s high), 04 MULHSU (s×u high), 05 MULHU (u×u high)
  - 06 DIV, 07 DIVU, 08 REM, 09 REMU
  - 0A SRL, 0B SRA (true arithmetic, on signed operand), 0C SLL
  - 0D XOR, 0E OR, 0F AND
  - 10 EQ, 11 NE, 12 LT signed, 13 GE signed, 14 LTU, 15 GEU
- Compare ops: result = {0…, flag}.
- States and transitions:
  - IDLE: on accept, go to DONE (single-cycle ops, illegal, div special cases), MUL, or DIV.
  - MUL: multiply iterations; go to DONE after the last iteration.
  - DIV: divide iterations; go to DONE after the last iteration.
  - DONE: go to IDLE when out_ready.
- Operands and opcode are latched at accept. Later changes on a, b or opcode do not affect the operation in flight.
- Multiply:
  - Operands are converted to magnitudes per signedness, then shift-add runs one bit per cycle for XLEN cycles into a 2·XLEN product.
  - The product is negated when the result sign (sign_a ^ sign_b, signed operands only) is 1.
  - Result is the low or high half per opcode.
- Divide:
  - Restoring divide on magnitudes, one quotient bit per cycle for XLEN cycles.
  - Quotient sign = sign_a ^ sign_b; remainder takes the sign of the dividend.
- Divide special cases, resolved in IDLE with no iterations:
  - b==0: quotient all-ones, remainder = a (signed and unsigned).
  - Signed a = −2^(XLEN−1) with b = −1: quotient = a, remainder 0.
- result, alu_flag and illegal are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, alu_flag 0, illegal 0, internal accumulators 0. in_ready is 0 while rst=1.
- Reset mid-operation aborts immediately. No result is produced for the aborted operation, and in_ready=1 on the first cycle after rst deasserts.
- Accept happens on a rising edge with in_valid && in_ready.
- Latency from the accept edge to the first cycle with out_valid=1:
  - Single-cycle ops, illegal opcodes and divide special cases: 1 cycle.
  - MUL*: XLEN+1 cycles.
  - DIV*/REM*: XLEN+1 cycles.
- Hand-off: the result transfers on an edge with out_valid && out_ready. out_valid falls and in_ready rises on the next cycle.
- No overlap: in_ready stays 0 from accept until the result transfers. Throughput is one op per 2 cycles at best.
- in_valid held with in_ready=0 is ignored; the requester holds in_valid until in_ready.
- ADD/SUB wrap modulo 2^XLEN; no overflow indication.

## Test plan
- Reset/idle, XLEN=32: assert rst for 3 cycles during a MUL → out_valid=0, result=0; in_ready=1 on the first cycle after release; no stale result appears.
- Single-cycle ops:
  - ADD 0xFFFFFFFF+1 → 0x00000000 at accept+1.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LT 0xFFFFFFFF vs 1 → result 1, flag 1.
  - LTU same operands → result 0, flag 0.
- Multiply:
  - MUL −3×7 → 0xFFFFFFEB at accept+33.
  - MULH −1×−1 → 0.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Latency 33 for the normal cases above.
- Divide special cases, each at accept+1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- Backpressure and illegal opcodes:
  - Hold out_ready=0 for 10 cycles after XOR completes → result stable, in_ready=0; release → one transfer.
  - Opcode 5'b11111 → illegal=1, result 0 at accept+1.
  - Repeat all with XLEN=16: MUL latency 17, and 0x7FFF+1 → 0x8000.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for the sequential ALU.
// The issuing side is master; the ALU is slave.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      opcode;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            alu_flag;
  logic            illegal;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, alu_flag, illegal
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, alu_flag, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU.
// Multiply and divide run iteratively, one bit per cycle.
module seq_alu #(
  parameter int XLEN = 32
) (
  input logic   clk,
  input logic   rst,
  seq_alu_if.slave io
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h02, OP_MULH = 5'h03;
  localparam logic [4:0] OP_MULHSU = 5'h04, OP_MULHU = 5'h05;
  localparam logic [4:0] OP_DIV = 5'h06, OP_DIVU = 5'h07;
  localparam logic [4:0] OP_REM = 5'h08, OP_REMU = 5'h09;
  localparam logic [4:0] OP_SRL = 5'h0A, OP_SRA = 5'h0B;
  localparam logic [4:0] OP_SLL = 5'h0C, OP_XOR = 5'h0D;
  localparam logic [4:0] OP_OR = 5'h0E, OP_AND = 5'h0F;
  localparam logic [4:0] OP_EQ = 5'h10, OP_NE = 5'h11;
  localparam logic [4:0] OP_LT = 5'h12, OP_GE = 5'h13;
  localparam logic [4:0] OP_LTU = 5'h14, OP_GEU = 5'h15;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] hi, lo, mc, result;
  logic [SW-1:0]   cnt;
  logic [4:0]      op;
  logic            neg_p, neg_r;
  logic            out_valid, alu_flag, illegal;

  assign io.in_ready  = (state == IDLE) && !rst;
  assign io.out_valid = out_valid;
  assign io.result    = result;
  assign io.alu_flag  = alu_flag;
  assign io.illegal   = illegal;

  logic            accept;
  logic [SW-1:0]   shamt;
  logic            sa, sb, is_mul, is_div, ill;
  logic            d_zero, d_ovf, one_flag;
  logic [XLEN-1:0] one_res, spec_res, ma, mb;

  assign accept = io.in_valid && io.in_ready;
  assign shamt  = io.b[SW-1:0];
  assign ma     = sa ? -io.a : io.a;
  assign mb     = sb ? -io.b : io.b;

  always_comb begin
    one_res  = '0;
    one_flag = 1'b0;
    spec_res = '0;
    sa       = 1'b0;
    sb       = 1'b0;
    is_mul   = io.opcode inside {[OP_MUL:OP_MULHU]};
    is_div   = io.opcode inside {[OP_DIV:OP_REMU]};
    ill      = io.opcode >= 5'h16;
    d_zero   = io.b == '0;
    d_ovf    = (io.opcode inside {OP_DIV, OP_REM})
            && io.a == MIN && io.b == '1;
    if (io.opcode inside {OP_MUL, OP_MULH, OP_MULHSU,
                          OP_DIV, OP_REM})
      sa = io.a[XLEN-1];
    if (io.opcode inside {OP_MUL, OP_MULH, OP_DIV, OP_REM})
      sb = io.b[XLEN-1];
    unique case (io.opcode)
      OP_ADD:  one_res = io.a + io.b;
      OP_SUB:  one_res = io.a - io.b;
      OP_SRL:  one_res = io.a >> shamt;
      OP_SRA:  one_res = $signed(io.a) >>> shamt;
      OP_SLL:  one_res = io.a << shamt;
      OP_XOR:  one_res = io.a ^ io.b;
      OP_OR:   one_res = io.a | io.b;
      OP_AND:  one_res = io.a & io.b;
      OP_EQ:   one_flag = io.a == io.b;
      OP_NE:   one_flag = io.a != io.b;
      OP_LT:   one_flag = $signed(io.a) < $signed(io.b);
      OP_GE:   one_flag = $signed(io.a) >= $signed(io.b);
      OP_LTU:  one_flag = io.a < io.b;
      OP_GEU:  one_flag = io.a >= io.b;
      default: one_res = '0;
    endcase
    if (io.opcode inside {[OP_EQ:OP_GEU]})
      one_res = XLEN'(one_flag);
    // Zero divisor wins over signed overflow
    if (d_zero)
      spec_res = io.opcode inside {OP_DIV, OP_DIVU} ? '1 : io.a;
    else if (d_ovf)
      spec_res = io.opcode == OP_DIV ? io.a : '0;
  end

  // Shift-add step: hi accumulates, lo holds the multiplier
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res;

  assign msum    = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
  assign prod    = {msum, lo[XLEN-1:1]};
  assign prod_s  = neg_p ? -prod : prod;
  assign mul_res = op == OP_MUL ? prod_s[XLEN-1:0]
                                : prod_s[2*XLEN-1:XLEN];

  // Restoring step: hi is the partial remainder, lo the quotient
  logic [XLEN:0]   dtry, ddiff;
  logic            dge;
  logic [XLEN-1:0] drem, dquo, div_res;

  assign dtry  = {hi, lo[XLEN-1]};
  assign ddiff = dtry - {1'b0, mc};
  assign dge   = !ddiff[XLEN];
  assign drem  = dge ? ddiff[XLEN-1:0] : dtry[XLEN-1:0];
  assign dquo  = {lo[XLEN-2:0], dge};

  always_comb begin
    div_res = '0;
    if (op inside {OP_DIV, OP_DIVU})
      div_res = neg_p ? -dquo : dquo;
    else
      div_res = neg_r ? -drem : drem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      mc        <= '0;
      cnt       <= '0;
      op        <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      alu_flag  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op    <= io.opcode;
          neg_p <= sa ^ sb;
          neg_r <= sa;
          cnt   <= '0;
          if (is_mul) begin
            hi    <= '0;
            lo    <= mb;
            mc    <= ma;
            state <= MUL;
          end else if (is_div && !(d_zero || d_ovf)) begin
            hi    <= '0;
            lo    <= ma;
            mc    <= mb;
            state <= DIV;
          end else begin
            result    <= is_div ? spec_res : one_res;
            alu_flag  <= one_flag;
            illegal   <= ill;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        MUL: begin
          hi  <= msum[XLEN:1];
          lo  <= {msum[0], lo[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == SW'(XLEN-1)) begin
            result    <= mul_res;
            alu_flag  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DIV: begin
          hi  <= drem;
          lo  <= dquo;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(XLEN-1)) begin
            result    <= div_res;
            alu_flag  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
